load_access_unit: RTL

//  Sequential load unit; parametrised successor of the combinational load extractor.
//  - Accepts a load request (address, funct3 type, tag) over a valid/ready handshake.
//  - Issues one or two aligned reads to data memory over a req/gnt/rvalid interface.
//  - Merges beats, extracts, sign/zero-extends, returns result + tag over valid/ready.
//  - Sits between the execute stage and the data-memory port.

---
 rtl/load_access_unit_pkg.sv | 46 ++++
 rtl/load_access_unit_if.sv | 40 ++++
 rtl/load_access_unit_extract.sv | 35 +++
 rtl/load_access_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/load_access_unit_pkg.sv
// Shared types and helpers for the load access unit: funct3 load encodings,
// FSM states, and per-type size / signedness / legality decode.
package lsu_pkg;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LD  = 3'b011,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101,
      LT_LWU = 3'b110,
      LT_RSV = 3'b111
   } load_type_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      RESP  = 3'd5
   } lau_state_e;

   function automatic logic [3:0] load_size(load_type_e t);
      case (t)
         LT_LB, LT_LBU: return 4'd1;
         LT_LH, LT_LHU: return 4'd2;
         LT_LW, LT_LWU: return 4'd4;
         LT_LD:         return 4'd8;
         default:       return 4'd1;
      endcase
   endfunction

   function automatic logic load_signed(load_type_e t);
      return (t == LT_LB) || (t == LT_LH) || (t == LT_LW);
   endfunction

   // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
   function automatic logic load_legal(load_type_e t, int xlen);
      if (t == LT_RSV) return 1'b0;
      if ((xlen == 32) && ((t == LT_LD) || (t == LT_LWU))) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/load_access_unit_if.sv
// Bundle of the request, data-memory and response channels of the load unit.
// slave = the load unit itself, master = the execute stage / memory side.
interface load_access_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
) ();
   // valid/ready: a transfer happens on a rising edge where both are high; the
   // sender holds valid and payload stable until then. Memory: o_mem_req and
   // o_mem_addr hold until i_mem_gnt; data returns later with i_mem_rvalid.
   logic              i_req_valid;
   logic              o_req_ready;
   logic [ADDR_W-1:0] i_req_addr;
   logic [2:0]        i_req_type;
   logic [TAG_W-1:0]  i_req_tag;
   logic              o_mem_req;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              i_mem_gnt;
   logic              i_mem_rvalid;
   logic [XLEN-1:0]   i_mem_rdata;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [XLEN-1:0]   o_rsp_data;
   logic [TAG_W-1:0]  o_rsp_tag;
   logic              o_rsp_err;

   modport slave (
      input  i_req_valid, i_req_addr, i_req_type, i_req_tag,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
      output o_req_ready, o_mem_req, o_mem_addr,
      output o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err
   );

   modport master (
      output i_req_valid, i_req_addr, i_req_type, i_req_tag,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
      input  o_req_ready, o_mem_req, o_mem_addr,
      input  o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err
   );
endinterface

// File: rtl/load_access_unit_extract.sv
// Combinational load extractor: shifts the merged beats down by the byte
// offset, keeps the access size and sign- or zero-extends to XLEN.
module load_extract
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0]         beats,
   input  logic [$clog2(XLEN/8)-1:0] ofs,
   input  load_type_e                ld_type,
   output logic [XLEN-1:0]           result
);
   localparam int BYTES = XLEN / 8;

   logic [XLEN-1:0] sh;
   logic [3:0]      size;
   logic            msb;
   logic            fill;

   always_comb begin
      sh   = XLEN'(beats >> {ofs, 3'b000});
      size = load_size(ld_type);
      case (size)
         4'd1:    msb = sh[7];
         4'd2:    msb = sh[15];
         4'd4:    msb = sh[31];
         default: msb = sh[XLEN-1];
      endcase
      fill   = load_signed(ld_type) & msb;
      result = '0;
      for (int i = 0; i < BYTES; i++) begin
         result[i*8 +: 8] = (i < int'(size)) ? sh[i*8 +: 8] : {8{fill}};
      end
   end
endmodule

// File: rtl/load_access_unit.sv
// Sequential load unit: one request at a time, one or two aligned memory beats,
// registered extended response. `define MISALIGN_SPLIT_EN to service misaligned loads.
module load_access_unit
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic                i_clk,
   input  logic                i_reset,
   load_access_unit_if.slave   bus,
   output lau_state_e          dbg_state
);
   localparam int BYTES = XLEN / 8;
   localparam int OFS_W = $clog2(BYTES);

   lau_state_e        state, state_n;
   load_type_e        req_type, type_q;
   logic [OFS_W-1:0]  req_ofs, ofs_q;
   logic [3:0]        req_size;
   logic              req_misalign, req_cross, req_err, accept, cross_q;
   logic [XLEN-1:0]   beat0_q, beat0_in, ext_data;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic [TAG_W-1:0]  rsp_tag_q;
   logic              rsp_err_q;

   assign req_type     = load_type_e'(bus.i_req_type);
   assign req_ofs      = bus.i_req_addr[OFS_W-1:0];
   assign req_size     = load_size(req_type);
   assign req_misalign = (req_ofs & OFS_W'(req_size - 4'd1)) != '0;
   assign accept       = bus.i_req_valid && bus.o_req_ready;

`ifdef MISALIGN_SPLIT_EN
   assign req_cross = (int'(req_ofs) + int'(req_size)) > BYTES;
   assign req_err   = !load_legal(req_type, XLEN);
`else
   assign req_cross = 1'b0;
   assign req_err   = !load_legal(req_type, XLEN) || req_misalign;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = req_err ? RESP : REQ0;
         REQ0:    if (bus.i_mem_gnt) state_n = WAIT0;
         WAIT0:   if (bus.i_mem_rvalid) state_n = cross_q ? REQ1 : RESP;
         REQ1:    if (bus.i_mem_gnt) state_n = WAIT1;
         WAIT1:   if (bus.i_mem_rvalid) state_n = RESP;
         RESP:    if (bus.i_rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.o_req_ready = (state == IDLE) && !i_reset;
      bus.o_mem_req   = (state == REQ0) || (state == REQ1);
      bus.o_rsp_valid = (state == RESP);
      dbg_state       = state;
   end

   assign bus.o_mem_addr = mem_addr_q;
   assign bus.o_rsp_data = rsp_data_q;
   assign bus.o_rsp_tag  = rsp_tag_q;
   assign bus.o_rsp_err  = rsp_err_q;

   // The first beat is taken straight from the bus in WAIT0 so a single-beat
   // load can register its result in the same cycle the data arrives.
   assign beat0_in = (state == WAIT0) ? bus.i_mem_rdata : beat0_q;

   load_extract #(.XLEN(XLEN)) u_extract (
      .beats   ({bus.i_mem_rdata, beat0_in}),
      .ofs     (ofs_q),
      .ld_type (type_q),
      .result  (ext_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         type_q     <= LT_LB;
         ofs_q      <= '0;
         cross_q    <= 1'b0;
         beat0_q    <= '0;
         mem_addr_q <= '0;
         rsp_data_q <= '0;
         rsp_tag_q  <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            type_q     <= req_type;
            ofs_q      <= req_ofs;
            cross_q    <= req_cross;
            mem_addr_q <= {bus.i_req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            rsp_tag_q  <= bus.i_req_tag;
            if (req_err) begin
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b1;
            end
         end
         if ((state == WAIT0) && bus.i_mem_rvalid) begin
            beat0_q <= bus.i_mem_rdata;
            if (cross_q) begin
               mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
            end else begin
               rsp_data_q <= ext_data;
               rsp_err_q  <= 1'b0;
            end
         end
         if ((state == WAIT1) && bus.i_mem_rvalid) begin
            rsp_data_q <= ext_data;
            rsp_err_q  <= 1'b0;
         end
      end
   end
endmodule
